// File: rtl/life_gen_controller.sv
// Generation sequencer for a 4x4 life tile: pattern load, free-run every PERIOD+2 cycles, single-step.
// Load takes 3 cycles (ack on the third); a step takes 2. Inputs are ignored outside IDLE/WAIT/HALT.
module life_gen_controller #(
  parameter int PERIOD         = 8,
  parameter int GEN_W          = 16,
  parameter bit STOP_ON_STABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_req,
  input  logic [15:0]      load_val,
  output logic             load_ack,
  input  logic             run,
  input  logic             single_step,
  output logic [15:0]      arr_val,
  output logic             arr_write_enb,
  output logic             arr_step,
  input  logic [15:0]      arr_alive,
  input  logic [15:0]      arr_alive_prev,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             extinct,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, LD_SETUP, LD_WRITE, LD_DONE, STEP, SETTLE, WAIT, HALT
  } state_t;

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          stable_nxt, extinct_nxt;

  // The array has already advanced by the time SETTLE sees its outputs.
  assign stable_nxt  = (arr_alive == arr_alive_prev);
  assign extinct_nxt = (arr_alive == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_req)                state_nxt = LD_SETUP;
        else if (single_step || run) state_nxt = STEP;
      end
      LD_SETUP: state_nxt = LD_WRITE;
      LD_WRITE: state_nxt = LD_DONE;
      LD_DONE:  state_nxt = IDLE;
      STEP:     state_nxt = SETTLE;
      SETTLE: begin
        if (STOP_ON_STABLE && run && (stable_nxt || extinct_nxt)) state_nxt = HALT;
        else if (run)                                             state_nxt = WAIT;
        else                                                      state_nxt = IDLE;
      end
      WAIT: begin
        if (load_req)          state_nxt = LD_SETUP;
        else if (!run)         state_nxt = IDLE;
        else if (timer == '0)  state_nxt = STEP;
      end
      HALT: begin
        if (load_req)  state_nxt = LD_SETUP;
        else if (!run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arr_step      = (state == STEP);
    arr_write_enb = (state == LD_WRITE);
    load_ack      = (state == LD_DONE);
    busy          = (state != IDLE) && (state != HALT);
  end

  // LD_SETUP is only ever entered from IDLE/WAIT/HALT, so this latches once per load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arr_val   <= '0;
      timer     <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
    end else begin
      if (state_nxt == LD_SETUP) arr_val <= load_val;

      if (state == SETTLE)                     timer <= TW'(PERIOD - 1);
      else if (state == WAIT && timer != '0)   timer <= timer - TW'(1);

      if (state == LD_DONE) begin
        gen_count <= '0;
        stable    <= 1'b0;
        extinct   <= 1'b0;
      end else if (state == SETTLE) begin
        gen_count <= gen_count + GEN_W'(1);
        stable    <= stable_nxt;
        extinct   <= extinct_nxt;
      end
    end
  end

endmodule
